// File: rtl/uart_pkg.sv
// Shared definitions for the UART port controller.
// Holds the TX sequencer state encoding, the status and config bit
// positions, and the default I/O port indices.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StBusy  = 2'd2
    } tx_state_e;

    // Status word bit positions
    localparam int unsigned StatRxRdy = 0;
    localparam int unsigned StatTxRdy = 1;
    localparam int unsigned StatRxOvr = 2;
    localparam int unsigned StatTxOvr = 3;

    // Config word field positions
    localparam int unsigned CfgBaudLsb = 0;
    localparam int unsigned CfgBaudMsb = 3;
    localparam int unsigned CfgEight   = 4;
    localparam int unsigned CfgPen     = 5;
    localparam int unsigned CfgOhel    = 6;

    // Default port indices
    localparam int unsigned DefTxPort   = 0;
    localparam int unsigned DefCfgPort  = 1;
    localparam int unsigned DefMaskPort = 2;

endpackage

// File: rtl/uart_tx_seq.sv
// Transmit launch sequencer: IDLE -> START (one-cycle tx_start) -> BUSY,
// back to IDLE on tx_done. Latches the byte to send and flags writes that
// arrive while a transmit is in flight.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   wr_i, wr_data_i  TX data write strobe and byte
//   clr_ovr_i        status read, clears tx_ovr
//   tx_done_i        end-of-stop-bit pulse from the transmitter
//   tx_start_o       launch pulse; tx_data_o latched byte
//   tx_rdy_o         sequencer idle; tx_rdy_rise_o BUSY->IDLE this edge
//   tx_ovr_o         dropped-write flag
module uart_tx_seq
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_i,
    input  logic [7:0] wr_data_i,
    input  logic       clr_ovr_i,
    input  logic       tx_done_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic       tx_rdy_o,
    output logic       tx_rdy_rise_o,
    output logic       tx_ovr_o
);

    tx_state_e  state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_ovr_q, tx_ovr_d;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_ovr_d  = tx_ovr_q;
        // Clear first so a same-cycle dropped write keeps the flag set
        if (clr_ovr_i) begin
            tx_ovr_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (wr_i) begin
                    tx_data_d = wr_data_i;
                    state_d   = StStart;
                end
            end
            StStart: begin
                state_d = StBusy;
                if (wr_i) begin
                    tx_ovr_d = 1'b1;
                end
            end
            StBusy: begin
                if (tx_done_i) begin
                    state_d = StIdle;
                end
                if (wr_i) begin
                    tx_ovr_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            tx_data_q <= 8'h00;
            tx_ovr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_ovr_q  <= tx_ovr_d;
        end
    end

    assign tx_start_o    = (state_q == StStart);
    assign tx_rdy_o      = (state_q == StIdle);
    assign tx_rdy_rise_o = (state_q == StBusy) && tx_done_i;
    assign tx_data_o     = tx_data_q;
    assign tx_ovr_o      = tx_ovr_q;

endmodule

// File: rtl/uart_port_ctrl.sv
// Port-mapped UART controller on the Tramelblaze I/O bus.
// Holds UART config, the received byte and status flags, the read mux and
// the interrupt handshake; transmit sequencing lives in uart_tx_seq.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   WRITES, READS            one-hot decoded port strobes
//   OUT_PORT / IN_PORT       processor write / read data
//   INTERRUPT, INTERRUPT_ACK interrupt request and acknowledge pulse
//   tx_start, tx_data, tx_done   transmitter interface
//   rx_data, rx_done             receiver interface
//   baud_sel, eight, pen, ohel   UART configuration
// Optional: define UART_INT_MASK_EN to add a per-source interrupt mask
// register at MASK_PORT.
module uart_port_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned TX_PORT   = DefTxPort,
    parameter int unsigned CFG_PORT  = DefCfgPort,
    parameter int unsigned MASK_PORT = DefMaskPort
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] WRITES,
    input  logic [15:0] READS,
    input  logic [15:0] OUT_PORT,
    output logic [15:0] IN_PORT,
    output logic        INTERRUPT,
    input  logic        INTERRUPT_ACK,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [3:0]  baud_sel,
    output logic        eight,
    output logic        pen,
    output logic        ohel
);

    logic wr_tx, wr_cfg, rd_rx, rd_stat, rd_mask;
    assign wr_tx   = WRITES[TX_PORT];
    assign wr_cfg  = WRITES[CFG_PORT];
    assign rd_rx   = READS[TX_PORT];
    assign rd_stat = READS[CFG_PORT];
    assign rd_mask = READS[MASK_PORT];

    // Other strobe bits and upper data bits are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^{WRITES, READS, OUT_PORT[15:7]};

    logic tx_rdy, tx_rdy_rise, tx_ovr;

    uart_tx_seq u_tx_seq (
        .clk           (clk),
        .reset         (reset),
        .wr_i          (wr_tx),
        .wr_data_i     (OUT_PORT[7:0]),
        .clr_ovr_i     (rd_stat),
        .tx_done_i     (tx_done),
        .tx_start_o    (tx_start),
        .tx_data_o     (tx_data),
        .tx_rdy_o      (tx_rdy),
        .tx_rdy_rise_o (tx_rdy_rise),
        .tx_ovr_o      (tx_ovr)
    );

    logic [6:0] cfg_q, cfg_d;
    logic [7:0] rx_hold_q, rx_hold_d;
    logic       rx_rdy_q, rx_rdy_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       int_q, int_d;
    logic [1:0] mask;
    logic       rx_rdy_rise;

`ifdef UART_INT_MASK_EN
    logic [1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (WRITES[MASK_PORT]) begin
            mask_d = OUT_PORT[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= 2'b11;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask = mask_q;
`else
    assign mask = 2'b11;
`endif

    // rx_done always wins over a same-cycle read; it overruns only if the
    // held byte would otherwise have stayed unread
    assign rx_rdy_rise = rx_done && !rx_rdy_q;

    always_comb begin
        cfg_d     = cfg_q;
        rx_hold_d = rx_hold_q;
        rx_rdy_d  = rx_rdy_q;
        rx_ovr_d  = rx_ovr_q;
        int_d     = int_q;

        if (wr_cfg) begin
            cfg_d = OUT_PORT[6:0];
        end

        if (rd_rx) begin
            rx_rdy_d = 1'b0;
        end
        if (rd_stat) begin
            rx_ovr_d = 1'b0;
        end
        if (rx_done) begin
            rx_hold_d = rx_data;
            rx_rdy_d  = 1'b1;
            if (rx_rdy_q && !rd_rx) begin
                rx_ovr_d = 1'b1;
            end
        end

        if (INTERRUPT_ACK) begin
            int_d = 1'b0;
        end
        if ((rx_rdy_rise && mask[0]) || (tx_rdy_rise && mask[1])) begin
            int_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q     <= 7'b001_0000;  // eight=1, everything else 0
            rx_hold_q <= 8'h00;
            rx_rdy_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            rx_hold_q <= rx_hold_d;
            rx_rdy_q  <= rx_rdy_d;
            rx_ovr_q  <= rx_ovr_d;
            int_q     <= int_d;
        end
    end

    always_comb begin
        IN_PORT = 16'h0000;
        if (rd_rx) begin
            IN_PORT = {8'h00, rx_hold_q};
        end else if (rd_stat) begin
            IN_PORT[StatRxRdy] = rx_rdy_q;
            IN_PORT[StatTxRdy] = tx_rdy;
            IN_PORT[StatRxOvr] = rx_ovr_q;
            IN_PORT[StatTxOvr] = tx_ovr;
        end else if (rd_mask) begin
`ifdef UART_INT_MASK_EN
            IN_PORT = {14'h0000, mask};
`else
            IN_PORT = 16'h0000;
`endif
        end
    end

    assign INTERRUPT = int_q;
    assign baud_sel  = cfg_q[CfgBaudMsb:CfgBaudLsb];
    assign eight     = cfg_q[CfgEight];
    assign pen       = cfg_q[CfgPen];
    assign ohel      = cfg_q[CfgOhel];

endmodule
